// File: rtl/fpga_pkg.sv
// Shared requester-index type and sizing defaults for the memory-port arbiter.
// Also supplies fallback AXI4 width macros when the surrounding build has not set them.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 512
`endif

package fpga_pkg;

    localparam int MemArbDefaultNumReq  = 2;
    localparam int MemArbMaxOutstanding = 4;
    localparam int MemArbPerfCntWidth   = 32;

    typedef logic [$clog2(MemArbDefaultNumReq)-1:0] arb_idx_t;

    // Index width that stays at least one bit wide for single-entry cases.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order tracker of granted requester indices; the head names the owner of the
// next memory response. Head is read combinationally so responses route with zero latency.
module mem_arb_id_fifo
    import fpga_pkg::*;
#(
    parameter int  Depth = MemArbMaxOutstanding,
    parameter type T     = arb_idx_t
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    output T                           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PtrW = idx_width(Depth);
    localparam int CntW = $clog2(Depth + 1);

    T                storage_reg [Depth];
    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [CntW-1:0] count_reg;
    logic [CntW-1:0] count_next;
    logic            push_ok;
    logic            pop_ok;

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_reg == CntW'(Depth));
    assign empty_o = (count_reg == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = storage_reg[rd_ptr_reg];
    assign count_o = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CntW'(1);
            2'b01:   count_next = count_reg - CntW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            storage_reg[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wrap_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= wrap_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NumReq requesters, with in-order
// response routing. Optional performance counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import fpga_pkg::*;
#(
    parameter int NumReq         = 2,
    parameter int AddrWidth      = `AXI4_ADDR_WIDTH,
    parameter int DataWidth      = `AXI4_DATA_WIDTH,
    parameter int MaxOutstanding = MemArbMaxOutstanding
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]  strb_i,
    input  logic [NumReq-1:0]                   we_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [NumReq-1:0]                   rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic                                mem_req_o,
    input  logic                                mem_gnt_i,
    output logic [AddrWidth-1:0]                mem_addr_o,
    output logic [DataWidth-1:0]                mem_wdata_o,
    output logic [DataWidth/8-1:0]              mem_strb_o,
    output logic                                mem_we_o,
    input  logic                                mem_rvalid_i,
    input  logic [DataWidth-1:0]                mem_rdata_i,
    output logic                                err_o
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [NumReq-1:0][MemArbPerfCntWidth-1:0] perf_gnt_cnt_o,
    output logic [MemArbPerfCntWidth-1:0]             perf_stall_cnt_o
`endif
);

    localparam int IdxW = idx_width(NumReq);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    typedef logic [IdxW-1:0] idx_t;

    idx_t            ptr_reg;
    idx_t            ptr_next;
    idx_t            sel_idx;
    idx_t            head_idx;
    idx_t            cand_idx;
    int              cand;
    logic            found;
    logic            any_req;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            handshake;
    logic            err_reg;

    // First asserted request at or after the priority pointer, wrapping around.
    always_comb begin
        sel_idx  = ptr_reg;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand     = (int'(ptr_reg) + k) % NumReq;
            cand_idx = idx_t'(cand);
            if (!found && req_i[cand_idx]) begin
                found   = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    assign any_req     = |req_i;
    assign mem_req_o   = rstn_i && any_req && !fifo_full;
    assign handshake   = mem_req_o && mem_gnt_i;
    assign mem_addr_o  = addr_i[sel_idx];
    assign mem_wdata_o = wdata_i[sel_idx];
    assign mem_strb_o  = strb_i[sel_idx];
    assign mem_we_o    = we_i[sel_idx];
    assign rdata_o     = mem_rdata_i;
    assign err_o       = err_reg;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_route
        assign gnt_o[gi]    = handshake && (sel_idx == idx_t'(gi));
        assign rvalid_o[gi] = rstn_i && mem_rvalid_i && !fifo_empty && (head_idx == idx_t'(gi));
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (handshake) begin
            ptr_next = (sel_idx == idx_t'(NumReq - 1)) ? '0 : sel_idx + idx_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            if (mem_rvalid_i && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    mem_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .T     (idx_t)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (handshake),
        .data_i  (sel_idx),
        .pop_i   (mem_rvalid_i),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_count_bounded: assert property (@(posedge clk_i) disable iff (!rstn_i)
        fifo_count <= CntW'(MaxOutstanding));

`ifdef MEM_ARB_PERF_CNT_EN
    logic [MemArbPerfCntWidth-1:0] gnt_cnt_reg [NumReq];
    logic [MemArbPerfCntWidth-1:0] stall_cnt_reg;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_perf_gnt
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                gnt_cnt_reg[gi] <= '0;
            end else if (gnt_o[gi] && (gnt_cnt_reg[gi] != '1)) begin
                gnt_cnt_reg[gi] <= gnt_cnt_reg[gi] + MemArbPerfCntWidth'(1);
            end
        end
        assign perf_gnt_cnt_o[gi] = gnt_cnt_reg[gi];
    end

    // Stalls include cycles blocked by a full tracker, not just a deasserted mem_gnt_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_reg <= '0;
        end else if (any_req && !handshake && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + MemArbPerfCntWidth'(1);
        end
    end

    assign perf_stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requesters sharing one memory port (2..8).
REQ-002 SHALL have parameter AddrWidth, default `AXI4_ADDR_WIDTH, memory address width.
REQ-003 SHALL have parameter DataWidth, default `AXI4_DATA_WIDTH (512), memory data width; strobe width DataWidth/8.
REQ-004 SHALL have parameter MaxOutstanding, default 4, maximum granted-but-unanswered requests (power of 2, 1..16).
REQ-005 SHALL have ports clk_i input 1 (single clock, rising edge) and rstn_i input 1 (asynchronous, active-low reset).
REQ-006 SHALL have requester side: req_i in [NumReq], addr_i in [NumReq][AddrWidth], wdata_i in [NumReq][DataWidth], strb_i in [NumReq][DataWidth/8], we_i in [NumReq], gnt_o out [NumReq], rvalid_o out [NumReq], rdata_o out [DataWidth] (shared, qualified by rvalid_o).
REQ-007 SHALL have memory side: mem_req_o out 1, mem_gnt_i in 1, mem_addr_o out AddrWidth, mem_wdata_o out DataWidth, mem_strb_o out DataWidth/8, mem_we_o out 1, mem_rvalid_i in 1, mem_rdata_i in DataWidth.
REQ-008 SHALL have err_o out 1: sticky protocol-error flag.

Function
REQ-009 SHALL select one requester per cycle round-robin among asserted req_i, starting search at priority pointer ptr, wrapping NumReq-1 -> 0.
REQ-010 SHALL drive mem_req_o = (any req_i) AND NOT full; mem_addr/wdata/strb/we_o are the selected requester's fields, combinationally (zero added latency).
REQ-011 SHALL assert gnt_o[i] only for selected i, only in cycles where mem_req_o AND mem_gnt_i; at most one gnt_o bit high per cycle.
REQ-012 SHALL advance ptr to (granted index + 1) mod NumReq on handshake only; ptr holds when no handshake, so a stalled requester keeps priority.
REQ-013 SHALL push granted index into an in-order ID FIFO of depth MaxOutstanding on each handshake; every handshake (read or write) expects exactly one mem_rvalid_i.
REQ-014 SHALL, on mem_rvalid_i, pop FIFO head h, assert rvalid_o[h] same cycle, rdata_o = mem_rdata_i (pass-through, no register).
REQ-015 SHALL define full = (count == MaxOutstanding); grant is blocked when full even if a pop occurs the same cycle.
REQ-016 SHALL support simultaneous push and pop when not full: count unchanged, both pointers advance.
REQ-017 SHALL, on mem_rvalid_i with FIFO empty, assert no rvalid_o, leave count at 0, and set err_o (held until reset).
REQ-018 SHALL never drop or reorder responses; response ordering equals grant ordering.

Reset
REQ-019 SHALL asynchronously on rstn_i low clear: ptr=0, FIFO pointers/count=0, err_o=0, perf counters (if built)=0.
REQ-020 SHALL, while in reset, drive mem_req_o=0, gnt_o=0, rvalid_o=0; data outputs follow muxes (don't-care).
REQ-021 SHALL discard outstanding entries on reset mid-operation; late mem_rvalid_i after reset release sets err_o.

Configuration
REQ-022 SHALL, with MEM_ARB_PERF_CNT_EN defined, add outputs perf_gnt_cnt_o [NumReq][32] (handshakes per requester) and perf_stall_cnt_o [32] (cycles with any req_i and no handshake), both saturating at 2^32-1.
REQ-023 SHALL, without MEM_ARB_PERF_CNT_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-024 SHALL place requester-index type (arb_idx_t, $clog2(NumReq) bits) and MemArbMaxOutstanding default in fpga_pkg.
REQ-025 SHALL implement the in-order ID tracker as sub-module mem_arb_id_fifo (params Depth, type; push/pop/full/empty/count, async active-low reset).
REQ-026 SHALL keep the arbiter free of DPI calls; memory model stays in the downstream slave.

Verification
REQ-027 SHALL cover: req_i=2'b11 held, mem_gnt_i=1 constant -> grants alternate 0,1,0,1; each rvalid_o routed to matching index.
REQ-028 SHALL cover: req_i=2'b01, mem_gnt_i=0 for 5 cycles then 1 -> gnt_o[0] only in cycle 6; ptr unchanged in cycles 1-5.
REQ-029 SHALL cover: MaxOutstanding=4, 4 grants with no mem_rvalid_i -> mem_req_o=0 next cycle despite req_i; pulse mem_rvalid_i -> grant resumes the following cycle, not the same.
REQ-030 SHALL cover: write from req 1 (we_i=1, strb_i=all-ones, addr 0x100) then read req 0 at 0x100 -> mem_we_o=1 then 0, responses in order rvalid_o[1] then rvalid_o[0].
REQ-031 SHALL cover: mem_rvalid_i with empty FIFO -> no rvalid_o, err_o=1 until rstn_i low.
REQ-032 SHALL cover: rstn_i low with 3 outstanding -> count=0, err_o=0 immediately; MEM_ARB_PERF_CNT_EN build: 10 grants to req 0 -> perf_gnt_cnt_o[0]=10.
